// File: rtl/fp16_pkg.sv
// Shared types, constants and FP16 arithmetic for the dot-product datapath.
// Subnormal operands and results flush to signed zero; rounding is to nearest, ties to even.
package fp16_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } state_e;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam int MAC_PIPE_DEPTH = 2;

    function automatic logic [15:0] fp16_mul_f(
        input logic [15:0] x,
        input logic [15:0] y
    );
        logic        s;
        logic [4:0]  ex;
        logic [4:0]  ey;
        logic [21:0] p;
        logic [9:0]  frac;
        logic        g;
        logic        st;
        logic [14:0] r;
        int          e;
        s  = x[15] ^ y[15];
        ex = x[14:10];
        ey = y[14:10];
        if ((ex == 5'h1f && x[9:0] != 10'd0) || (ey == 5'h1f && y[9:0] != 10'd0))
            return FP16_QNAN;
        if (ex == 5'h1f || ey == 5'h1f) begin
            if (ex == 5'd0 || ey == 5'd0)
                return FP16_QNAN;
            return {s, 5'h1f, 10'd0};
        end
        if (ex == 5'd0 || ey == 5'd0)
            return {s, 15'd0};
        p = 22'({1'b1, x[9:0]}) * 22'({1'b1, y[9:0]});
        e = int'(ex) + int'(ey) - 15;
        if (p[21]) begin
            frac = p[20:11];
            g    = p[10];
            st   = |p[9:0];
            e    = e + 1;
        end else begin
            frac = p[19:10];
            g    = p[9];
            st   = |p[8:0];
        end
        if (e >= 31)
            return {s, 5'h1f, 10'd0};
        if (e <= 0)
            return {s, 15'd0};
        // A mantissa carry ripples into the exponent field, up to infinity.
        r = {5'(e), frac} + 15'(g & (st | frac[0]));
        return {s, r};
    endfunction

    function automatic logic [15:0] fp16_add_f(
        input logic [15:0] x,
        input logic [15:0] y
    );
        logic [15:0] hi;
        logic [15:0] lo;
        logic [4:0]  d;
        logic [13:0] ma;
        logic [13:0] mb;
        logic [13:0] mask;
        logic [14:0] s;
        logic [9:0]  frac;
        logic        g;
        logic        st;
        logic [14:0] r;
        int          e;
        if ((x[14:10] == 5'h1f && x[9:0] != 10'd0) ||
            (y[14:10] == 5'h1f && y[9:0] != 10'd0))
            return FP16_QNAN;
        if (x[14:10] == 5'h1f && y[14:10] == 5'h1f)
            return (x[15] != y[15]) ? FP16_QNAN : x;
        if (x[14:10] == 5'h1f)
            return x;
        if (y[14:10] == 5'h1f)
            return y;
        if (x[14:10] == 5'd0 && y[14:10] == 5'd0)
            return {x[15] & y[15], 15'd0};
        if (x[14:10] == 5'd0)
            return y;
        if (y[14:10] == 5'd0)
            return x;
        if (x[14:0] < y[14:0]) begin
            hi = y;
            lo = x;
        end else begin
            hi = x;
            lo = y;
        end
        d    = hi[14:10] - lo[14:10];
        ma   = {1'b1, hi[9:0], 3'b000};
        mb   = {1'b1, lo[9:0], 3'b000};
        mask = 14'd0;
        if (d >= 5'd14) begin
            mb = 14'd1;
        end else begin
            mask = (14'd1 << d) - 14'd1;
            st   = |(mb & mask);
            mb   = (mb >> d) | {13'd0, st};
        end
        if (hi[15] == lo[15])
            s = {1'b0, ma} + {1'b0, mb};
        else
            s = {1'b0, ma} - {1'b0, mb};
        if (s == 15'd0)
            return FP16_ZERO;
        e = int'(hi[14:10]);
        if (s[14]) begin
            s = {1'b0, s[14:2], s[1] | s[0]};
            e = e + 1;
        end else begin
            for (int i = 0; i < 13; i++) begin
                if (!s[13]) begin
                    s = s << 1;
                    e = e - 1;
                end
            end
        end
        frac = s[12:3];
        g    = s[2];
        st   = |s[1:0];
        if (e >= 31)
            return {hi[15], 5'h1f, 10'd0};
        if (e <= 0)
            return {hi[15], 15'd0};
        r = {5'(e), frac} + 15'(g & (st | frac[0]));
        return {hi[15], r};
    endfunction

endpackage

// File: rtl/fp16_add.sv
// Combinational FP16 adder.
module fp16_add
    import fp16_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] s_o
);

    assign s_o = fp16_add_f(a_i, b_i);

endmodule

// File: rtl/fp16_mac_pipe.sv
// Two-stage multiply / accumulate pipe; only stage-2 valid products reach the accumulator.
module fp16_mac_pipe
    import fp16_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        vld_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic        v1_o,
    output logic [15:0] acc_o
);

    logic [15:0] a1_q;
    logic [15:0] b1_q;
    logic        v1_q;
    logic [15:0] p2_q;
    logic        v2_q;
    logic [15:0] acc_q;
    logic [15:0] acc_d;
    logic [15:0] prod;
    logic [15:0] sum;

    fp16_mul u_mul (
        .a_i (a1_q),
        .b_i (b1_q),
        .p_o (prod)
    );

    fp16_add u_add (
        .a_i (p2_q),
        .b_i (acc_q),
        .s_o (sum)
    );

    always_comb begin
        acc_d = acc_q;
        if (clr_i)
            acc_d = FP16_ZERO;
        else if (v2_q)
            acc_d = sum;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a1_q  <= FP16_ZERO;
            b1_q  <= FP16_ZERO;
            v1_q  <= 1'b0;
            p2_q  <= FP16_ZERO;
            v2_q  <= 1'b0;
            acc_q <= FP16_ZERO;
        end else begin
            v1_q  <= vld_i;
            v2_q  <= v1_q;
            acc_q <= acc_d;
            if (vld_i) begin
                a1_q <= a_i;
                b1_q <= b_i;
            end
            if (v1_q)
                p2_q <= prod;
        end
    end

    assign v1_o  = v1_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/fp16_mul.sv
// Combinational FP16 multiplier.
module fp16_mul
    import fp16_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] p_o
);

    assign p_o = fp16_mul_f(a_i, b_i);

endmodule

// File: rtl/fp16_dot_ctrl.sv
// Job sequencer for the FP16 dot product: start/len framing, operand stream,
// pipeline drain and a held result handshake.
module fp16_dot_ctrl
    import fp16_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      result
);

    state_e           state_q;
    state_e           state_d;
    logic [LEN_W-1:0] rem_q;
    logic [LEN_W-1:0] rem_d;
    logic             clr;
    logic             accept;
    logic             v1;

    assign in_ready  = (state_q == LOAD);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clr = 1'b1;
                    if (len != '0) begin
                        rem_d   = len;
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1))
                        state_d = DRAIN;
                end
            end
            // With stage 1 empty, the last product is in stage 2 and lands this edge.
            DRAIN: begin
                if (!v1)
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    fp16_mac_pipe u_mac (
        .clk_i (clk),
        .rst_i (reset),
        .clr_i (clr),
        .vld_i (accept),
        .a_i   (a),
        .b_i   (b),
        .v1_o  (v1),
        .acc_o (result)
    );

endmodule

// File: doc/fp16_dot_ctrl.md
# fp16_dot_ctrl

Sequencer that computes an FP16 dot product of a streamed vector pair using the team's FP16 multiplier and adder. It accepts a start command with a vector length and streams operand pairs over a valid/ready handshake. It clears the accumulator per job, gates pipeline bubbles so that only valid products are accumulated, and waits for the pipeline to drain. It then presents the final sum on a valid/ready result port. The block sits between an operand-fetch/DMA front end and any consumer of FP16 dot-product results, replacing the free-running MAC in contexts that need job framing.

## Interface
- LEN_W, 8: width of the vector-length field; maximum job length 2^LEN_W−1 pairs.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs in the job; sampled with start.
- busy  out  1  high in every state other than IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  high only in LOAD.
- a, b  in  16  FP16 operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  16  FP16 dot product; equals accumulator.

## Operation
- Reset values: busy=0, in_ready=0, out_valid=0, result=16'h0000; state=IDLE; counters, pipeline valids and the accumulator are all 0.
- IDLE:
  - On start=1 with len≠0: clear the accumulator to 16'h0000, load remaining=len, and go to LOAD.
  - On start=1 with len=0: clear the accumulator and go directly to DONE (result +0).
- LOAD:
  - in_ready=1. Each in_valid&&in_ready edge captures a and b into stage-1 registers with v1=1 and decrements remaining.
  - Cycles with in_valid=0 insert v1=0 bubbles.
  - When the final pair is accepted (remaining==1), go to DRAIN. in_ready drops in the following cycle.
- Pipeline:
  - Stage 2 registers the multiplier output with v2=v1.
  - The accumulator takes adder(product_reg, accumulator) only when v2=1. Otherwise it holds.
  - Bubbles never alter the accumulator.
- DRAIN: wait until v1=0 and v2=0 and the final product has been accumulated, then go to DONE.
- DONE:
  - out_valid=1 and result is stable.
  - On out_ready=1, go to IDLE; out_valid drops in the following cycle.
- start is ignored while busy=1.
- len is captured once; changes during the job have no effect.
- FP16 arithmetic (rounding, specials) is exactly that of the existing multiplier and adder. No extra normalisation.

## Timing
- The last pair is accepted on edge E:
  - product registered at E+1;
  - accumulator final at E+2;
  - state=DONE and out_valid=1 from E+2.
- The drain latency is fixed at 2 cycles after the last acceptance, independent of bubbles.
- Minimum job duration for len=N with no bubbles: 1 (start) + N + 2 cycles to out_valid.
- For len=0, out_valid is high one edge after start.
- Result handshake: the result transfers on the edge where out_valid&&out_ready. start may be asserted in the cycle immediately after and is accepted from IDLE.
- If out_ready is low, out_valid and result are held indefinitely.
- Reset mid-job (any state) immediately returns the block to IDLE and clears all outputs and pipeline state. No partial result is emitted.

## Structure
- Shared package fp16_pkg:
  - state enum (IDLE, LOAD, DRAIN, DONE);
  - FP16_ZERO=16'h0000;
  - MAC_PIPE_DEPTH=2.
- Sub-module fp16_mac_pipe holds:
  - stage-1 and stage-2 registers with valid bits;
  - instances of the existing multiplier and adder;
  - a synchronous clear input and the valid-gated accumulator.
- The top level holds the FSM, the remaining counter and the handshakes.

## Test plan
- len=1, pair (0x4000, 0x4200): result=0x4600 (6.0); out_valid rises 3 edges after start; in_ready is high for exactly 1 cycle.
- len=4, four pairs (0x3C00, 0x3C00) with in_valid low for 2 cycles between pairs 2 and 3: result=0x4400 (4.0); the accumulator is unchanged during bubbles.
- len=0: out_valid one edge after start with result=0x0000; in_ready never asserted.
- Back-to-back jobs: job 1 of 2×(0x4000,0x4000) gives 0x4800. Job 2 of len=1, (0x3C00,0x3C00), gives 0x3C00, proving the clear. start asserted while busy is ignored.
- Backpressure: out_ready held low for 5 cycles in DONE; out_valid and result stay stable; transfer occurs on the first out_ready=1 edge.
- Reset asserted mid-LOAD after 2 of 4 pairs: busy, in_ready, out_valid=0 and result=0x0000 immediately. A subsequent len=1 job of (0x4000,0x4200) returns 0x4600.
